// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button conditioner.
package btn_pkg;

  localparam int unsigned CLK_HZ = 65_000_000;

  // Default timing: ~15.4 ms debounce, 0.5 s repeat delay, 0.1 s repeat period.
  localparam int unsigned DB_COUNT_DEF      = CLK_HZ / 65;
  localparam int unsigned REPEAT_DELAY_DEF  = CLK_HZ / 2;
  localparam int unsigned REPEAT_PERIOD_DEF = CLK_HZ / 10;

  localparam int unsigned N_CH_DEF = 5;

  // Board channel indices.
  localparam int unsigned BTN_C = 0;
  localparam int unsigned BTN_U = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_L = 3;
  localparam int unsigned BTN_R = 4;

  // Width of a counter that must reach count-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, stability-counter debounce,
// registered rise/fall pulses and, with BTN_AUTOREPEAT_EN defined,
// hold-to-repeat pulses. Without the macro repeat_out is tied low.
module btn_chan
  import btn_pkg::*;
#(
  parameter int unsigned DB_COUNT      = DB_COUNT_DEF,
  parameter int unsigned CNT_W         = cnt_width(DB_COUNT),
  parameter logic        ACTIVE_LOW    = 1'b0,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter int unsigned RPT_W         = cnt_width(REPEAT_DELAY)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic clean_out,
  output logic rise_out,
  output logic fall_out,
  output logic repeat_out,
  output logic rise_next_out
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_COUNT - 1);

  logic             s1_q, s2_q;
  logic             cand_q, cand_d;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             update;

  // Polarity correction then two-flop synchroniser.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in ^ ACTIVE_LOW;
      s2_q <= s1_q;
    end
  end

  assign update = (s2_q == cand_q) && (cand_q != clean_q) && (cnt_q == DbLast);

  // Debounce next state: new candidate restarts the count, stable candidate commits.
  always_comb begin
    cand_d  = cand_q;
    clean_d = clean_q;
    cnt_d   = cnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cand_q != clean_q) begin
      if (cnt_q == DbLast) begin
        clean_d = cand_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = update & cand_q & ~clean_q;
    fall_d = update & ~cand_q & clean_q;
  end

  // Debounce state and edge pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cand_q  <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_out     = clean_q;
  assign rise_out      = rise_q;
  assign fall_out      = fall_q;
  assign rise_next_out = rise_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] DelayLast  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PeriodLast = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             first_q, first_d;
  logic             rpt_q, rpt_d;

  // Repeat next state: a rise rearms the long first delay.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    first_d   = first_q;
    rpt_d     = 1'b0;
    if (rise_d) begin
      rpt_cnt_d = '0;
      first_d   = 1'b1;
    end else if (clean_q) begin
      if (rpt_cnt_q == (first_q ? DelayLast : PeriodLast)) begin
        rpt_d     = 1'b1;
        rpt_cnt_d = '0;
        first_d   = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end else begin
      rpt_cnt_d = '0;
    end
  end

  // Repeat counter, first-delay flag and pulse register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rpt_cnt_q <= '0;
      first_q   <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      first_q   <= first_d;
      rpt_q     <= rpt_d;
    end
  end

  assign repeat_out = rpt_q;
`else
  assign repeat_out = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: one btn_chan per input plus a registered
// OR of all rise pulses. Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned      N_CH          = N_CH_DEF,
  parameter int unsigned      DB_COUNT      = DB_COUNT_DEF,
  parameter int unsigned      CNT_W         = cnt_width(DB_COUNT),
  parameter logic [N_CH-1:0]  ACTIVE_LOW    = '0,
  parameter int unsigned      REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned      REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter int unsigned      RPT_W         = cnt_width(REPEAT_DELAY)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] repeat_out,
  output logic            any_rise_out
);

  logic [N_CH-1:0] rise_next;
  logic            any_rise_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    btn_chan #(
      .DB_COUNT      (DB_COUNT),
      .CNT_W         (CNT_W),
      .ACTIVE_LOW    (ACTIVE_LOW[i]),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .RPT_W         (RPT_W)
    ) u_chan (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .btn_in        (btn_in[i]),
      .clean_out     (clean_out[i]),
      .rise_out      (rise_out[i]),
      .fall_out      (fall_out[i]),
      .repeat_out    (repeat_out[i]),
      .rise_next_out (rise_next[i])
    );
  end

  // OR the per-channel next-state pulses so any_rise_out lines up with rise_out.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      any_rise_q <= 1'b0;
    end else begin
      any_rise_q <= |rise_next;
    end
  end

  assign any_rise_out = any_rise_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (DB_COUNT=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, N_CH=3, channel 2 active-low). Repeat checks follow
// BTN_AUTOREPEAT_EN.
module tb_btn_conditioner;

  localparam int unsigned N_CH = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] clean, rise, fall, rpt;
  logic            any_rise;

  int total = 0;
  int bad   = 0;

  btn_conditioner #(
    .N_CH          (N_CH),
    .DB_COUNT      (4),
    .CNT_W         (2),
    .ACTIVE_LOW    (3'b100),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3),
    .RPT_W         (4)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .btn_in       (btn),
    .clean_out    (clean),
    .rise_out     (rise),
    .fall_out     (fall),
    .repeat_out   (rpt),
    .any_rise_out (any_rise)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected repeat pulse k cycles after the rise edge while held.
  function automatic logic rep_exp(input int k);
`ifdef BTN_AUTOREPEAT_EN
    return (k >= 10) && (k <= 28) && (((k - 10) % 3) == 0);
`else
    return (k < 0) && (k > 0);
`endif
  endfunction

  initial begin
    rst = 1'b1;
    btn = 3'b100;  // channel 2 idle-high (active-low)
    step(3);
    check_eq("rst_clean", 32'(clean), 32'h0);
    check_eq("rst_rise", 32'(rise), 32'h0);
    check_eq("rst_fall", 32'(fall), 32'h0);
    check_eq("rst_rpt", 32'(rpt), 32'h0);
    check_eq("rst_any", 32'(any_rise), 32'h0);
    rst = 1'b0;
    step(2);

    // Channel 0 press, hold, release so clean falls 30 cycles after the rise.
    btn[0] = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      step(1);
      check_eq($sformatf("t1_clean_%0d", i), 32'(clean), 32'((i >= 7 && i < 37) ? 1 : 0));
      check_eq($sformatf("t1_rise_%0d", i), 32'(rise), 32'((i == 7) ? 1 : 0));
      check_eq($sformatf("t1_fall_%0d", i), 32'(fall), 32'((i == 37) ? 1 : 0));
      check_eq($sformatf("t1_any_%0d", i), 32'(any_rise), 32'((i == 7) ? 1 : 0));
      check_eq($sformatf("t1_rpt_%0d", i), 32'(rpt), 32'(rep_exp(i - 7)));
      if (i == 30) btn[0] = 1'b0;
    end

    // Channel 1: 3-cycle glitch is filtered out.
    btn[1] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      if (i == 3) btn[1] = 1'b0;
      check_eq($sformatf("t2g_clean_%0d", i), 32'(clean[1]), 32'h0);
      check_eq($sformatf("t2g_rise_%0d", i), 32'(rise[1]), 32'h0);
      check_eq($sformatf("t2g_fall_%0d", i), 32'(fall[1]), 32'h0);
    end

    // Channel 1: 5-cycle pulse passes: one rise, later one fall.
    btn[1] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 5) btn[1] = 1'b0;
      check_eq($sformatf("t2p_clean_%0d", i), 32'(clean[1]), 32'((i >= 7 && i < 12) ? 1 : 0));
      check_eq($sformatf("t2p_rise_%0d", i), 32'(rise[1]), 32'((i == 7) ? 1 : 0));
      check_eq($sformatf("t2p_fall_%0d", i), 32'(fall[1]), 32'((i == 12) ? 1 : 0));
    end

    // Channel 2 active-low: drive low to press.
    btn[2] = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      check_eq($sformatf("t3_clean_%0d", i), 32'(clean[2]), 32'((i >= 7) ? 1 : 0));
      check_eq($sformatf("t3_rise_%0d", i), 32'(rise[2]), 32'((i == 7) ? 1 : 0));
      check_eq($sformatf("t3_fall_%0d", i), 32'(fall[2]), 32'h0);
    end

    // Channels 0 and 1 pressed on the same edge.
    btn[1:0] = 2'b11;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      check_eq($sformatf("t4_rise_%0d", i), 32'(rise), 32'((i == 7) ? 3'b011 : 3'b000));
      check_eq($sformatf("t4_any_%0d", i), 32'(any_rise), 32'((i == 7) ? 1 : 0));
    end

    // Reset mid-debounce with the input still held.
    rst = 1'b1;
    btn = 3'b100;
    step(2);
    rst = 1'b0;
    step(2);
    btn[0] = 1'b1;
    step(5);  // edges 0..4 passed: counter now at 2
    rst = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step(1);
      check_eq($sformatf("t5_rst_rise_%0d", i), 32'(rise), 32'h0);
      check_eq($sformatf("t5_rst_clean_%0d", i), 32'(clean), 32'h0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      check_eq($sformatf("t5_rise_%0d", i), 32'(rise), 32'((i == 7) ? 1 : 0));
      check_eq($sformatf("t5_clean_%0d", i), 32'(clean), 32'((i >= 7) ? 1 : 0));
      check_eq($sformatf("t5_any_%0d", i), 32'(any_rise), 32'((i == 7) ? 1 : 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
